fp_seq_gen_multi: RTL

Parametrised successor to the single-mode sequence generator. It writes the first `n` terms of an arithmetic sequence a1, a1+d, a1+2d, … to memory through a request/ready write port. Terms are produced by running accumulation in either IEEE-754 single precision or 32-bit two's-complement integer, selected per run. The block sits between the control register file (operands, activate) and the shared memory write port, and adds a configurable address stride, sticky overflow reporting and early abort.

---
 rtl/fp_seq_gen_multi_if.sv | 24 ++
 rtl/fp_seq_gen_multi.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_seq_gen_multi_if.sv
// Memory write port between the sequence generator and shared memory.
// master: mem_addr/mem_wdata/mem_write out, mem_ready in; slave mirrors it.
interface fp_seq_gen_multi_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_write;
    logic              mem_ready;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_write,
        input  mem_ready
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_write,
        output mem_ready
    );
endinterface

// File: rtl/fp_seq_gen_multi.sv
// Writes n terms of an FP32 or int32 arithmetic sequence to memory.
// Ports: clk, rst, activate/mode/a1/d/n/saddr in; done/busy/ovf out; mem port.
module fp_seq_gen_multi #(
    parameter int CNT_W     = 32,
    parameter int ADDR_W    = 32,
    parameter int ADDR_STEP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              activate,
    input  logic              mode,
    input  logic [31:0]       a1,
    input  logic [31:0]       d,
    input  logic [CNT_W-1:0]  n,
    input  logic [ADDR_W-1:0] saddr,
    output logic              done,
    output logic              busy,
    output logic              ovf,
    fp_seq_gen_multi_if.master mem
);

    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_ADD,
        ST_DONE
    } state_t;

    state_t state, state_nx;

    logic [31:0]       acc;
    logic [31:0]       d_q;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  n_q;
    logic              mode_q;

    logic              accept;
    logic              last;
    logic [32:0]       fp_r;
    logic [31:0]       int_sum;
    logic              int_ovf;
    logic [31:0]       add_res;
    logic              add_ovf;

    // Returns {overflow, sum}. RNE, flush-to-zero on inputs and results.
    function automatic logic [32:0] fp32_add(
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic        swap, s_big, s_sml, found, rnd;
        logic [7:0]  e_big, e_sml, diff;
        logic [22:0] f_big, f_sml;
        logic [26:0] m_big, m_sml, al, mask, nrm;
        logic [27:0] sum;
        logic [9:0]  e_res;
        logic [4:0]  lz;
        logic [24:0] mr;
        logic [32:0] r;

        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);

        swap  = (b[30:0] > a[30:0]);
        s_big = swap ? b[31]    : a[31];
        s_sml = swap ? a[31]    : b[31];
        e_big = swap ? b[30:23] : a[30:23];
        e_sml = swap ? a[30:23] : b[30:23];
        f_big = swap ? b[22:0]  : a[22:0];
        f_sml = swap ? a[22:0]  : b[22:0];

        diff  = e_big - e_sml;
        m_big = {1'b1, f_big, 3'b000};
        m_sml = {1'b1, f_sml, 3'b000};
        mask  = 27'd0;
        if (diff >= 8'd27) begin
            al = 27'd1;
        end else begin
            // Bits shifted out collapse into the sticky bit.
            mask = (27'd1 << diff) - 27'd1;
            al   = (m_sml >> diff) | {26'd0, |(m_sml & mask)};
        end

        if (s_big == s_sml)
            sum = {1'b0, m_big} + {1'b0, al};
        else
            sum = {1'b0, m_big} - {1'b0, al};

        e_res = {2'b00, e_big};
        lz    = 5'd0;
        found = 1'b0;
        if (sum[27]) begin
            nrm   = sum[27:1] | {26'd0, sum[0]};
            e_res = e_res + 10'd1;
        end else begin
            for (int i = 26; i >= 0; i--) begin
                if (!found && sum[i]) begin
                    lz    = 5'(26 - i);
                    found = 1'b1;
                end
            end
            nrm   = sum[26:0] << lz;
            e_res = e_res - {5'd0, lz};
        end

        rnd = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
        mr  = {1'b0, nrm[26:3]} + {24'd0, rnd};
        if (mr[24]) begin
            mr    = mr >> 1;
            e_res = e_res + 10'd1;
        end

        if (a_nan || b_nan)
            r = {1'b0, QNAN};
        else if (a_inf && b_inf)
            r = (a[31] != b[31]) ? {1'b1, QNAN} : {1'b0, a};
        else if (a_inf)
            r = {1'b0, a};
        else if (b_inf)
            r = {1'b0, b};
        else if (a_zero && b_zero)
            r = 33'd0;
        else if (a_zero)
            r = {1'b0, b};
        else if (b_zero)
            r = {1'b0, a};
        else if (sum == 28'd0)
            r = 33'd0;
        else if ($signed(e_res) <= 0)
            r = {1'b0, s_big, 31'd0};
        else if ($signed(e_res) >= 255)
            r = {1'b1, s_big, 8'hFF, 23'd0};
        else
            r = {1'b0, s_big, e_res[7:0], mr[22:0]};
        return r;
    endfunction

    assign fp_r    = fp32_add(acc, d_q);
    assign int_sum = acc + d_q;
    assign int_ovf = (acc[31] == d_q[31]) && (int_sum[31] != acc[31]);
    assign add_res = mode_q ? int_sum : fp_r[31:0];
    assign add_ovf = mode_q ? int_ovf : fp_r[32];

    // Gate on state rather than mem_write to keep the handshake loop-free.
    assign accept = (state == ST_WRITE) && mem.mem_ready;
    assign last   = (cnt == n_q - CNT_W'(1));

    assign mem.mem_addr  = addr;
    assign mem.mem_wdata = acc;

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        done          = 1'b0;
        busy          = 1'b0;
        mem.mem_write = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (activate)
                    state_nx = (n == '0) ? ST_DONE : ST_WRITE;
            end
            ST_WRITE: begin
                busy          = 1'b1;
                mem.mem_write = 1'b1;
                if (!activate)
                    state_nx = ST_IDLE;
                else if (accept)
                    state_nx = last ? ST_DONE : ST_ADD;
            end
            ST_ADD: begin
                busy     = 1'b1;
                state_nx = activate ? ST_WRITE : ST_IDLE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (!activate)
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            d_q    <= '0;
            addr   <= '0;
            cnt    <= '0;
            n_q    <= '0;
            mode_q <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (state == ST_IDLE && activate) begin
                acc    <= a1;
                d_q    <= d;
                addr   <= saddr;
                cnt    <= '0;
                n_q    <= n;
                mode_q <= mode;
                ovf    <= 1'b0;
            end
            // An aborting ADD cycle skips the update so ovf stays clean.
            if (state == ST_ADD && activate) begin
                acc  <= add_res;
                addr <= addr + ADDR_W'(ADDR_STEP);
                cnt  <= cnt + CNT_W'(1);
                if (add_ovf)
                    ovf <= 1'b1;
            end
        end
    end

endmodule
